// File: rtl/neighbor_fetch_pkg.sv
// Shared types and constants for the neighbour fetch block: FSM states,
// adjacency header field positions and the padding word value.
package neighbor_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        DONE
    } nf_state_e;

    // Header word: [31:16] list pointer, [15:0] degree
    localparam int PTR_MSB = 31;
    localparam int PTR_LSB = 16;
    localparam int DEG_MSB = 15;
    localparam int DEG_LSB = 0;

    localparam logic [31:0] NULL_WORD = 32'h0000_0000;

endpackage

// File: rtl/nf_skid_fifo.sv
// Small synchronous FIFO holding neighbour words that arrive while the
// consumer stalls; any depth >= 2, simultaneous push and pop allowed when full.
module nf_skid_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 48
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic [CW-1:0]               cnt;
    logic                        do_push, do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/neighbor_fetch.sv
// Reads a vertex adjacency header and streams its neighbour words with credit-based
// prefetch. Optional padding-word drop: define NEIGHBOR_FETCH_NULL_SKIP_EN.
module neighbor_fetch
    import neighbor_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_DEGREE   = 16,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [31:0]           mem_data_in,
    output logic [31:0]           vertex_out,
    output logic [ADDR_WIDTH-1:0] vertex_addr_out,
    output logic                  vertex_valid_out,
    input  logic                  vertex_ready_in,
    output logic                  done_out,
    output logic [15:0]           count_out,
    output logic                  clamp_err_out
);

    localparam int          FIFO_DEPTH   = BRAM_LATENCY + 1;
    localparam int          ENTRY_W      = ADDR_WIDTH + 32;
    localparam logic [2:0]  CREDITS_INIT = 3'(FIFO_DEPTH);
    localparam logic [2:0]  HDR_LAST     = 3'(BRAM_LATENCY);
    localparam logic [15:0] MAX_DEG16    = 16'(MAX_DEGREE);

    nf_state_e                               state, state_nxt;
    logic [2:0]                              hdr_cnt, credits;
    logic [ADDR_WIDTH-1:0]                   ptr, issue_addr, ret_addr;
    logic [15:0]                             deg_eff, issued, resolved, resolved_nxt, count;
    logic [15:0]                             hdr_deg, hdr_deg_eff;
    logic [BRAM_LATENCY:0]                   vld_pipe;
    logic [BRAM_LATENCY:0][ADDR_WIDTH-1:0]   addr_pipe;
    logic                                    accept, hdr_hit, issue, ret_vld, drop, word_vld;
    logic                                    transfer, push, pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]                      fifo_head;

    assign accept      = (state == IDLE) & req_valid_in;
    assign hdr_hit     = (state == HDR) & (hdr_cnt == HDR_LAST);
    assign hdr_deg     = mem_data_in[DEG_MSB:DEG_LSB];
    assign hdr_deg_eff = (hdr_deg > MAX_DEG16) ? MAX_DEG16 : hdr_deg;
    assign ret_vld     = vld_pipe[BRAM_LATENCY];
    assign ret_addr    = addr_pipe[BRAM_LATENCY];
    assign issue_addr  = ptr + ADDR_WIDTH'(issued);

`ifdef NEIGHBOR_FETCH_NULL_SKIP_EN
    assign drop = ret_vld & (mem_data_in == NULL_WORD);
`else
    assign drop = 1'b0;
`endif
    assign word_vld = ret_vld & ~drop;

    // Returning words bypass the FIFO when it is empty so a word is visible the
    // cycle it leaves the BRAM; only stalled words are queued.
    assign vertex_valid_out = ~fifo_empty | word_vld;
    assign {vertex_addr_out, vertex_out} = !fifo_empty ? fifo_head
                                         : (word_vld ? {ret_addr, mem_data_in} : '0);
    assign transfer = vertex_valid_out & vertex_ready_in;
    assign pop      = ~fifo_empty & vertex_ready_in;
    assign push     = word_vld & ~(fifo_empty & vertex_ready_in);

    // A credit freed this cycle can be spent this cycle, keeping one read per cycle.
    assign issue = (state == STREAM) & (issued != deg_eff)
                 & ((credits != '0) | transfer | drop);
    assign resolved_nxt = resolved + 16'(transfer) + 16'(drop);
    assign count_out    = count;

    nf_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .gclk      (clk_in),
        .grst_n    (rst_in),
        .push      (push),
        .push_data ({ret_addr, mem_data_in}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HDR;
            HDR:     if (hdr_hit) state_nxt = (hdr_deg_eff == '0) ? DONE : STREAM;
            STREAM:  if (resolved_nxt == deg_eff) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_out = (state == IDLE);
        done_out      = (state == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hdr_cnt       <= '0;
            credits       <= CREDITS_INIT;
            ptr           <= '0;
            deg_eff       <= '0;
            issued        <= '0;
            resolved      <= '0;
            count         <= '0;
            clamp_err_out <= 1'b0;
            mem_addr_out  <= '0;
            vld_pipe      <= '0;
            addr_pipe     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[BRAM_LATENCY-1:0], issue};
            addr_pipe <= {addr_pipe[BRAM_LATENCY-1:0], issue_addr};
            if (accept) begin
                hdr_cnt       <= '0;
                credits       <= CREDITS_INIT;
                issued        <= '0;
                resolved      <= '0;
                count         <= '0;
                clamp_err_out <= 1'b0;
                mem_addr_out  <= req_addr_in;
            end else begin
                if (state == HDR) hdr_cnt <= hdr_cnt + 3'd1;
                if (hdr_hit) begin
                    ptr     <= ADDR_WIDTH'(mem_data_in[PTR_MSB:PTR_LSB]);
                    deg_eff <= hdr_deg_eff;
                    if (hdr_deg > MAX_DEG16) clamp_err_out <= 1'b1;
                end
                if (issue) begin
                    mem_addr_out <= issue_addr;
                    issued       <= issued + 16'd1;
                end
                credits  <= credits + 3'(transfer) + 3'(drop) - 3'(issue);
                resolved <= resolved_nxt;
                count    <= count + 16'(transfer);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(push && fifo_full && !pop));

endmodule
